// File: rtl/data_mem_ctrl.sv
// Data memory controller: IDLE/ACCESS/RESP FSM, LATENCY-cycle access, little-endian RISC-V loads/stores.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of silently aligning them.
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        busy,
  output logic        ready,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [7:0]    mem [DEPTH_BYTES];

  logic          accept, done, mem_we, req_err, illegal, out_of_range;
  logic [3:0]    size;
  logic [2:0]    lsb_mask;
  logic [AW-1:0] base_idx;
  logic [63:0]   raw, load_val;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic          misalign;
`endif

  // Decode of the latched request; only consumed on the ACCESS-to-RESP edge.
  always_comb begin
    size         = 4'd1 << funct3_q[1:0];
    lsb_mask     = 3'(size - 4'd1);
    illegal      = we_q ? funct3_q[2] : (funct3_q == 3'b111);
    out_of_range = ({1'b0, addr_q} + 65'(size) - 65'd1) >= 65'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign     = |(addr_q[2:0] & lsb_mask);
    req_err      = illegal | out_of_range | misalign;
    base_idx     = addr_q[AW-1:0];
`else
    req_err      = illegal | out_of_range;
    base_idx     = addr_q[AW-1:0] & ~AW'(lsb_mask);
`endif
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      raw[8*i +: 8] = mem[base_idx + AW'(i)];
    end
    case (funct3_q)
      3'b000:  load_val = {{56{raw[7]}},  raw[7:0]};
      3'b001:  load_val = {{48{raw[15]}}, raw[15:0]};
      3'b010:  load_val = {{32{raw[31]}}, raw[31:0]};
      3'b011:  load_val = raw;
      3'b100:  load_val = {56'd0, raw[7:0]};
      3'b101:  load_val = {48'd0, raw[15:0]};
      3'b110:  load_val = {32'd0, raw[31:0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    accept   = req && ((state_q == IDLE) || (state_q == RESP));
    done     = (state_q == ACCESS) && (cnt_q == '0);
    mem_we   = done && we_q && !req_err;

    case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
               else cnt_d = cnt_q - 1'b1;
      RESP:    state_d = req ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      we_d     = we;
      funct3_d = funct3;
      addr_d   = addr;
      wdata_d  = wdata;
      cnt_d    = CW'(LATENCY - 1);
    end

    // Stores never disturb rdata, even when they fail.
    if (done) begin
      err_d = req_err;
      if (!we_q) rdata_d = req_err ? 64'd0 : load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Contents survive reset; reset only suppresses an in-flight write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(size)) mem[base_idx + AW'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    busy  = (state_q == ACCESS);
    ready = (state_q == RESP);
    err   = ready & err_q;
    rdata = rdata_q;
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: driver queues expected responses, monitor checks on ready.
module tb_data_mem_ctrl;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata, rdata;
  logic        busy, ready, err;

  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic        SW31_ERR = 1'b1;
  localparam logic [63:0] LD30_VAL = 64'h0;
`else
  localparam logic        SW31_ERR = 1'b0;
  localparam logic [63:0] LD30_VAL = 64'h0000_0000_DEAD_BEEF;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req_v);
    end
  endtask

  // Monitor: protocol checks every cycle, response checks whenever ready is seen.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0) chk("busy_xor_ready", 64'(busy ^ ready), 64'd1);
      if (!ready) chk("err_without_ready", 64'(err), 64'd0);
      if (ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ready: got ready=1 at cycle %0d, required no response", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk({mon_e.name, " rdata"}, rdata, mon_e.rdata);
          chk({mon_e.name, " err"}, 64'(err), 64'(mon_e.err));
          chk({mon_e.name, " latency"}, 64'(cyc - mon_e.acc), 64'(LAT + 1));
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [2:0] f, input logic [63:0] a, input logic [63:0] d);
    we = w; funct3 = f; addr = a; wdata = d;
  endtask

  // Called #1 after the accepting edge; that edge closed cycle cyc-1.
  task automatic push(input string nm, input logic [63:0] r, input logic e);
    exp_t x;
    x.name = nm; x.rdata = r; x.err = e; x.acc = cyc - 1;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic txn(input string nm, input logic w, input logic [2:0] f, input logic [63:0] a,
                     input logic [63:0] d, input logic [63:0] exp_r, input logic exp_e);
    drive(w, f, a, d);
    req = 1'b1;
    @(posedge clk); #1;
    push(nm, exp_r, exp_e);
    req = 1'b0;
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1;
    req   = 1'b0;
    drive(1'b0, 3'b000, 64'h0, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",  64'(busy),  64'd0);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset err",   64'(err),   64'd0);
    chk("reset rdata", rdata,      64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    txn("sd_10",   1'b1, 3'b011, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 1'b0);
    txn("ld_10",   1'b0, 3'b011, 64'h10, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
    txn("sb_20",   1'b1, 3'b000, 64'h20, 64'hFF, 64'h1122_3344_5566_7788, 1'b0);
    txn("lb_20",   1'b0, 3'b000, 64'h20, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    txn("lbu_20",  1'b0, 3'b100, 64'h20, 64'h0, 64'h0000_0000_0000_00FF, 1'b0);
    txn("sh_22",   1'b1, 3'b001, 64'h22, 64'h8001, 64'h0000_0000_0000_00FF, 1'b0);
    txn("lh_22",   1'b0, 3'b001, 64'h22, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    txn("lhu_22",  1'b0, 3'b101, 64'h22, 64'h0, 64'h0000_0000_0000_8001, 1'b0);
    txn("lw_14",   1'b0, 3'b010, 64'h14, 64'h0, 64'h0000_0000_1122_3344, 1'b0);
    txn("lwu_10",  1'b0, 3'b110, 64'h10, 64'h0, 64'h0000_0000_5566_7788, 1'b0);

    // Back-to-back: req stays high; the second request's fields sit on the bus during ACCESS.
    drive(1'b0, 3'b011, 64'h10, 64'h0);
    req = 1'b1;
    @(posedge clk); #1;
    push("b2b_ld", 64'h1122_3344_5566_7788, 1'b0);
    drive(1'b0, 3'b001, 64'h22, 64'h0);
    t = 0;
    while (!ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL b2b_first_ready: got no ready within 20 cycles, required ready");
    end
    @(posedge clk); #1;
    push("b2b_lh", 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    req = 1'b0;
    wait_drain();

    txn("ld_oob",  1'b0, 3'b011, 64'(DEPTH - 4), 64'h0, 64'h0, 1'b1);
    txn("ld_f111", 1'b0, 3'b111, 64'h10, 64'h0, 64'h0, 1'b1);
    txn("sd_30",   1'b1, 3'b011, 64'h30, 64'h0, 64'h0, 1'b0);
    txn("sw_31",   1'b1, 3'b010, 64'h31, 64'hDEAD_BEEF, 64'h0, SW31_ERR);
    txn("ld_30",   1'b0, 3'b011, 64'h30, 64'h0, LD30_VAL, 1'b0);
    txn("st_f100", 1'b1, 3'b100, 64'h38, 64'h55, LD30_VAL, 1'b1);
    txn("sd_40",   1'b1, 3'b011, 64'h40, 64'h0123_4567_89AB_CDEF, LD30_VAL, 1'b0);

    // Abort a store with reset during its first ACCESS cycle.
    drive(1'b1, 3'b011, 64'h40, 64'hAA);
    req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    req   = 1'b0;
    @(posedge clk); #1;
    chk("abort busy",  64'(busy),  64'd0);
    chk("abort ready", 64'(ready), 64'd0);
    chk("abort rdata", rdata,      64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    txn("ld_40",   1'b0, 3'b011, 64'h40, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0);

    txn("sw_48",   1'b1, 3'b010, 64'h48, 64'hFFFF_FFFF_8000_0000, 64'h0123_4567_89AB_CDEF, 1'b0);
    txn("lw_48",   1'b0, 3'b010, 64'h48, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_BYTES, default 256: data memory size in bytes; power of two, at least 8.
REQ-002 Parameter LATENCY, default 2: number of ACCESS-state cycles per request; at least 1.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port req, input, 1: access request from the core; sampled only in IDLE or RESP.
REQ-006 Port we, input, 1: 1 = store, 0 = load; sampled with req.
REQ-007 Port funct3, input, 3: access size and sign, using the RISC-V load/store encoding.
REQ-008 Port addr, input, 64: byte address taken from the ALU Result.
REQ-009 Port wdata, input, 64: store data taken from ReadData2; the low bytes are used.
REQ-010 Port rdata, output, 64: load result, zero- or sign-extended to 64 bits.
REQ-011 Port busy, output, 1: core stall request; high while in ACCESS.
REQ-012 Port ready, output, 1: one-cycle completion pulse; high while in RESP.
REQ-013 Port err, output, 1: error flag for the completing request; valid while ready is high.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-015 A request SHALL be accepted when req=1 in IDLE or RESP; on acceptance we, funct3, addr and wdata are latched, the FSM enters ACCESS, and the counter loads LATENCY-1.
REQ-016 In ACCESS the counter SHALL decrement each cycle; the FSM SHALL move to RESP on the edge where the counter is 0.
REQ-017 A request accepted at the end of cycle N SHALL have busy=1 in cycles N+1..N+LATENCY and ready=1 in cycle N+LATENCY+1 only.
REQ-018 When RESP sees req=0, the FSM SHALL return to IDLE; when RESP sees req=1, it SHALL accept the new request (back-to-back, no idle bubble).
REQ-019 req in ACCESS SHALL be ignored; the core is expected to hold req while busy, and that held request is not queued.
REQ-020 Memory SHALL be little-endian, byte-addressed, with no reset of its contents.
REQ-021 The memory write or read SHALL occur on the ACCESS-to-RESP edge using the latched request only.
REQ-022 Load funct3 decoding SHALL be:
- 000 LB (sign-extended), 001 LH (sign-extended), 010 LW (sign-extended), 011 LD.
- 100 LBU, 101 LHU, 110 LWU (zero-extended).
- 111 illegal.
REQ-023 Store funct3 decoding SHALL be: 000 SB, 001 SH, 010 SW, 011 SD; 1xx illegal.
REQ-024 A store SHALL write only the 1, 2, 4 or 8 addressed bytes from wdata[7:0], [15:0], [31:0] or [63:0] respectively.
REQ-025 The error condition SHALL be: illegal funct3, or addr+size-1 >= DEPTH_BYTES, or misalignment per REQ-033.
REQ-026 An erroring request SHALL NOT write memory, SHALL set rdata=0, and SHALL raise err=1 with ready.
REQ-027 rdata SHALL update only on a load's RESP entry and SHALL hold until the next load completes; stores and errors on stores leave rdata unchanged.
REQ-028 err SHALL be 0 whenever ready is 0.

Reset
REQ-029 While reset=1, the FSM SHALL go to IDLE, with busy=0, ready=0, err=0, rdata=0 and counter=0.
REQ-030 Reset SHALL take priority over req and over all FSM transitions.
REQ-031 Reset during ACCESS SHALL abort the request; no memory write occurs and no ready pulse follows.
REQ-032 Memory contents SHALL be preserved across reset.

Configuration
REQ-033 Macro DMEM_MISALIGN_TRAP_EN SHALL control misalignment handling:
- Defined: an access whose addr is not a multiple of its size is an error per REQ-026.
- Undefined: the low log2(size) address bits are forced to 0, and the access is performed aligned without error.

Verification
REQ-034 Store/load round trip: SD addr=0x10 wdata=0x1122334455667788, then LD addr=0x10 -> rdata=0x1122334455667788, err=0; ready exactly LATENCY+1 cycles after each accept.
REQ-035 Sign and zero extension: SB addr=0x20 wdata=0xFF, then LB -> rdata=0xFFFFFFFFFFFFFFFF and LBU -> rdata=0x00000000000000FF; SH 0x8001 at 0x22, then LH -> 0xFFFFFFFFFFFF8001.
REQ-036 Back-to-back requests: req held high across RESP for two loads -> ready pulses separated by exactly LATENCY+1 cycles, with busy never low between them except in RESP.
REQ-037 Errors: LD addr=DEPTH_BYTES-4 -> err=1, rdata=0; funct3=111 load -> err=1; SW addr=0x31 -> err=1 and memory at 0x30 unchanged with macro defined; the same SW writes 0x30..0x33 without err when the macro is undefined.
REQ-038 Reset mid-operation: SD 0xAA at 0x40, with reset asserted in the first ACCESS cycle -> busy=0 and ready=0 next cycle; a subsequent LD at 0x40 returns the prior contents.
